// File: rtl/gcd_engine.sv
// gcd_engine: iterative subtractive-Euclid GCD with valid/ready operand and result handshakes
// Defining GCD_ITER_LIMIT_EN aborts jobs that reach MAX_ITER subtractions (timeout_o=1).
module gcd_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = DATA_WIDTH,
  parameter int MAX_ITER   = 200
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  start_valid_i,
  output logic                  start_ready_o,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [DATA_WIDTH-1:0] gcd_o,
  output logic [CNT_WIDTH-1:0]  iter_cnt_o,
  output logic                  timeout_o
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] a_q, b_q, gcd_q;
  logic [CNT_WIDTH-1:0] cnt, iter_q;
  logic hit_limit;
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("DATA_WIDTH must be at least 2");
  end
`ifdef GCD_ITER_LIMIT_EN
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_ITER);
  logic timeout_q;
  assign hit_limit = cnt == LIMIT;
  always_ff @(posedge clk_i or negedge nreset_i)
    if (!nreset_i) timeout_q <= 1'b0;
    else if (state == IDLE && start_valid_i) timeout_q <= 1'b0;
    else if (state == CALC && a_q != b_q && hit_limit) timeout_q <= 1'b1;
  assign timeout_o = timeout_q;
`else
  if (MAX_ITER < 0) begin : g_bad_limit
    $error("MAX_ITER must be non-negative");
  end
  assign hit_limit = 1'b0;
  assign timeout_o = 1'b0;
`endif
  assign start_ready_o  = state == IDLE;
  assign result_valid_o = state == DONE;
  assign gcd_o          = gcd_q;
  assign iter_cnt_o     = iter_q;
  always_ff @(posedge clk_i or negedge nreset_i)
    if (!nreset_i) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      gcd_q  <= '0;
      iter_q <= '0;
    end else begin
      case (state)
        IDLE: if (start_valid_i) begin
          if (operand_a_i != '0 && operand_b_i != '0) begin
            a_q   <= operand_a_i;
            b_q   <= operand_b_i;
            cnt   <= '0;
            state <= CALC;
          end else begin
            // gcd(x,0)=x and gcd(0,0)=0 fall out of the OR
            gcd_q  <= operand_a_i | operand_b_i;
            iter_q <= '0;
            state  <= DONE;
          end
        end
        CALC: if (a_q == b_q) begin
          gcd_q  <= a_q;
          iter_q <= cnt;
          state  <= DONE;
        end else if (hit_limit) begin
          gcd_q  <= '0;
          iter_q <= cnt;
          state  <= DONE;
        end else begin
          if (a_q > b_q) a_q <= a_q - b_q;
          else b_q <= b_q - a_q;
          cnt <= cnt == CNT_MAX ? cnt : cnt + 1'b1;
        end
        DONE: if (result_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: vector table, corner sequences and random jobs against a division-based Euclid model
module tb_gcd_engine;
  localparam int DW = 8, CW = 8, MI = 100;
`ifdef GCD_ITER_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  logic clk = 1'b0, nreset = 1'b0, sv = 1'b0, rr = 1'b0;
  logic [DW-1:0] opa = '0, opb = '0;
  logic start_ready, result_valid, timeout;
  logic [DW-1:0] gcd;
  logic [CW-1:0] iter;
  int checks = 0, errors = 0;
  typedef struct { int a; int b; int g; int n; } vec_t;
  vec_t vt[$];
  always #5 clk = ~clk;
  gcd_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_ITER(MI)) dut (
    .clk_i(clk), .nreset_i(nreset), .start_valid_i(sv), .start_ready_o(start_ready),
    .operand_a_i(opa), .operand_b_i(opb), .result_valid_o(result_valid),
    .result_ready_i(rr), .gcd_o(gcd), .iter_cnt_o(iter), .timeout_o(timeout)
  );
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Subtraction count from Euclid quotients: q per step, q-1 on the final exact step.
  function automatic void model(input int a0, input int b0, output int g, output int n, output int t);
    int a = a0, b = b0, r;
    n = 0;
    t = 0;
    if (a == 0 || b == 0) begin
      g = a | b;
      return;
    end
    while (b != 0) begin
      r = a % b;
      n += (r == 0) ? a / b - 1 : a / b;
      a = b;
      b = r;
    end
    g = a;
    if (LIM && n > MI) begin
      g = 0;
      n = MI;
      t = 1;
    end
  endfunction
  function automatic int exp_lat(input int a, input int b, input int n);
    return (a == 0 || b == 0) ? 0 : n + 1;
  endfunction
  task automatic run_job(input int a, input int b, input int hold, output int g, output int n, output int t, output int lat);
    @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    sv = 1'b1;
    opa = DW'(a);
    opb = DW'(b);
    @(posedge clk);
    #1 sv = 1'b0;
    opa = DW'($urandom);
    opb = DW'($urandom);
    lat = 0;
    while (!result_valid && lat < 1000) begin
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 1000) check("result_valid_wait", 0, 1);
    g = gcd;
    n = iter;
    t = timeout;
    repeat (hold) begin
      @(posedge clk);
      #1 check("hold_gcd", gcd, g);
      check("hold_iter", iter, n);
      check("hold_valid", result_valid, 1);
    end
    rr = 1'b1;
    @(posedge clk);
    #1 rr = 1'b0;
    check("valid_drop", result_valid, 0);
    check("ready_back", start_ready, 1);
  endtask
  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int g, n, t, lat, eg, en, et, a, b;
    vt.push_back('{12, 18, 6, 2});
    vt.push_back('{0, 9, 9, 0});
    vt.push_back('{0, 0, 0, 0});
    vt.push_back('{9, 0, 9, 0});
    vt.push_back('{7, 7, 7, 0});
    vt.push_back('{1, 1, 1, 0});
    vt.push_back('{48, 36, 12, 3});
    vt.push_back('{100, 75, 25, 3});
    vt.push_back('{40, 24, 8, 3});
    #12;
    check("rst_start_ready", start_ready, 1);
    check("rst_valid", result_valid, 0);
    check("rst_gcd", gcd, 0);
    check("rst_iter", iter, 0);
    check("rst_timeout", timeout, 0);
    @(negedge clk) nreset = 1'b1;
    foreach (vt[i]) begin
      run_job(vt[i].a, vt[i].b, 0, g, n, t, lat);
      check($sformatf("gcd_%0d_%0d", vt[i].a, vt[i].b), g, vt[i].g);
      check($sformatf("iter_%0d_%0d", vt[i].a, vt[i].b), n, vt[i].n);
      check($sformatf("lat_%0d_%0d", vt[i].a, vt[i].b), lat, exp_lat(vt[i].a, vt[i].b, vt[i].n));
      check("timeout_clear", t, 0);
    end
`ifndef GCD_ITER_LIMIT_EN
    run_job(255, 1, 0, g, n, t, lat);
    check("gcd_255_1", g, 1);
    check("iter_255_1", n, 254);
    check("lat_255_1", lat, 255);
`else
    run_job(255, 1, 0, g, n, t, lat);
    check("limit_gcd", g, 0);
    check("limit_iter", n, MI);
    check("limit_timeout", t, 1);
    check("limit_lat", lat, MI + 1);
    run_job(12, 18, 0, g, n, t, lat);
    check("timeout_cleared", t, 0);
`endif
    // DONE holds under backpressure and ignores new operands
    @(negedge clk);
    sv = 1'b1;
    opa = 8'd7;
    opb = 8'd7;
    @(negedge clk);
    opa = 8'd3;
    opb = 8'd5;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", result_valid, 1);
      check("bp_start_ready", start_ready, 0);
      check("bp_gcd", gcd, 7);
      check("bp_iter", iter, 0);
    end
    sv = 1'b0;
    rr = 1'b1;
    @(negedge clk);
    rr = 1'b0;
    check("bp_release_valid", result_valid, 0);
    check("bp_release_idle", start_ready, 1);
    check("bp_gcd_held", gcd, 7);
    // reset in the middle of CALC
    @(negedge clk);
    sv = 1'b1;
    opa = 8'd200;
    opb = 8'd3;
    @(posedge clk);
    #1 sv = 1'b0;
    repeat (10) @(posedge clk);
    #2 nreset = 1'b0;
    #1 check("mid_rst_start_ready", start_ready, 1);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_gcd", gcd, 0);
    check("mid_rst_iter", iter, 0);
    check("mid_rst_timeout", timeout, 0);
    @(negedge clk) nreset = 1'b1;
    @(negedge clk) check("post_rst_no_result", result_valid, 0);
    run_job(40, 24, 1, g, n, t, lat);
    check("post_rst_gcd", g, 8);
    check("post_rst_iter", n, 3);
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      model(a, b, eg, en, et);
      run_job(a, b, $urandom_range(0, 3), g, n, t, lat);
      check($sformatf("rnd_gcd_%0d_%0d", a, b), g, eg);
      check($sformatf("rnd_iter_%0d_%0d", a, b), n, en);
      check($sformatf("rnd_to_%0d_%0d", a, b), t, et);
      check($sformatf("rnd_lat_%0d_%0d", a, b), lat, (a == 0 || b == 0) ? 0 : (et != 0 ? MI + 1 : en + 1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
